// File: rtl/fpu_issue_pkg.sv
// Shared types and default configuration for the FP add/sub issue controller.
// Tag-pipe entries track ops in the FU; result entries are what the result FIFO stores.
package fpu_issue_pkg;

    localparam int TAG_W_DEF     = 4;
    localparam int FU_LAT_DEF    = 3;
    localparam int RES_DEPTH_DEF = 4;
    localparam int DATA_W        = 32;

    typedef struct packed {
        logic                 occ;
        logic                 keep;
        logic [TAG_W_DEF-1:0] tag;
    } tp_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic                 exception;
        logic [TAG_W_DEF-1:0] tag;
    } res_entry_t;

    function automatic res_entry_t pack_result(
        input logic [DATA_W-1:0]    result,
        input logic                 exception,
        input logic [TAG_W_DEF-1:0] tag
    );
        res_entry_t e;
        e.result    = result;
        e.exception = exception;
        e.tag       = tag;
        return e;
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with a clear input; DEPTH must be a power of two so
// the pointers wrap naturally.
module fpu_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_cnt == FULL_CNT);
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign head_data = r_mem[r_rd_ptr];

    // Clear wins over both push and pop, so a coincident pop is discarded.
    assign w_push_ok = push & ~full & ~clr;
    assign w_pop_ok  = pop & ~empty & ~clr;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fpu_addsub_issue_ctrl.sv
// Issue controller for the fixed-latency FP add/sub unit: credit-gated admission,
// tag pipe matching FU done pulses, and a result FIFO absorbing writeback backpressure.
module fpu_addsub_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int FU_LAT    = FU_LAT_DEF,
    parameter int RES_DEPTH = RES_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fu_start,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    output logic             fu_sub,
    input  logic             fu_done,
    input  logic [31:0]      fu_result,
    input  logic             fu_exception,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_exception,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err_protocol
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = RES_DEPTH[CNT_W:0];

    tp_entry_t [FU_LAT-1:0] r_pipe;
    logic                   r_alive;
    logic                   r_err;

    tp_entry_t        w_last;
    res_entry_t       w_push_entry;
    res_entry_t       w_head_entry;
    logic [CNT_W-1:0] w_occ_cnt;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic [CNT_W:0]   w_credit_used;
    logic             w_any_occ;
    logic             w_accept;
    logic             w_push_req;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_done_err;
    logic             w_full_err;

    // Killed entries still hold a credit until they leave the pipe.
    always_comb begin
        w_occ_cnt = '0;
        w_any_occ = 1'b0;
        for (int i = 0; i < FU_LAT; i++) begin
            w_occ_cnt = w_occ_cnt + {{(CNT_W-1){1'b0}}, r_pipe[i].occ};
            w_any_occ = w_any_occ | r_pipe[i].occ;
        end
    end

    assign w_credit_used = {1'b0, w_occ_cnt} + {1'b0, w_fifo_cnt};
    assign in_ready      = r_alive & ~flush & (w_credit_used < CREDIT_MAX);
    assign w_accept      = in_valid & in_ready;

    assign fu_start = w_accept;
    assign fu_a     = in_a;
    assign fu_b     = in_b;
    assign fu_sub   = in_sub;

    // The oldest entry lines up with this cycle's fu_done.
    assign w_last       = r_pipe[FU_LAT-1];
    assign w_push_req   = fu_done & w_last.occ & w_last.keep & ~flush;
    assign w_push_entry = pack_result(fu_result, fu_exception, w_last.tag);
    assign w_done_err   = fu_done ^ w_last.occ;
    assign w_full_err   = w_push_req & w_fifo_full;
    assign w_pop        = ~w_fifo_empty & out_ready;

    // Gate admission until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Tag pipe: shifts every cycle; flush kills in-flight ops but keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0].occ  <= w_accept;
            r_pipe[0].keep <= w_accept;
            r_pipe[0].tag  <= in_tag;
            for (int i = 1; i < FU_LAT; i++) begin
                r_pipe[i].occ  <= r_pipe[i-1].occ;
                r_pipe[i].keep <= r_pipe[i-1].keep & ~flush;
                r_pipe[i].tag  <= r_pipe[i-1].tag;
            end
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_done_err | w_full_err) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    fpu_result_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (w_push_req),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head_entry),
        .count     (w_fifo_cnt),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign out_valid     = ~w_fifo_empty;
    assign out_result    = w_head_entry.result;
    assign out_exception = w_head_entry.exception;
    assign out_tag       = w_head_entry.tag;
    assign busy          = w_any_occ | ~w_fifo_empty;
    assign err_protocol  = r_err;

endmodule

// File: tb/tb_fpu_addsub_issue_ctrl.sv
// Bench for the FP add/sub issue controller: a 3-cycle FU model feeds done pulses,
// and a scoreboard queue checks every popped result in order.
module tb_fpu_addsub_issue_ctrl;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = 32'h0;
    logic [31:0]      in_b = 32'h0;
    logic             in_sub = 1'b0;
    logic [TAG_W-1:0] in_tag = 4'h0;
    logic             fu_start;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_sub;
    logic             fu_done;
    logic [31:0]      fu_result;
    logic             fu_exception;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic             out_exception;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             err_protocol;

    int total = 0;
    int bad = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    fpu_addsub_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_tag(in_tag),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub),
        .fu_done(fu_done), .fu_result(fu_result), .fu_exception(fu_exception),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_exception(out_exception), .out_tag(out_tag),
        .busy(busy), .err_protocol(err_protocol)
    );

    // FU behaviour: known IEEE cases from the plan, anything else is a^b.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == 32'h3F800000 && b == 32'h40000000 && !s) return 32'h40400000;
        if (a == 32'h40A00000 && b == 32'h40400000 && s)  return 32'h40000000;
        if (a == 32'h3F800000 && b == 32'h3F800000 && !s) return 32'h40000000;
        if (a == 32'h7F800000 && b == 32'hFF800000 && !s) return 32'h7FC00000;
        return a ^ b;
    endfunction

    function automatic logic ref_exc(input logic [31:0] a, input logic [31:0] b, input logic s);
        return (a == 32'h7F800000 && b == 32'hFF800000 && !s);
    endfunction

    logic [2:0]  fu_v;
    logic [31:0] fu_r0, fu_r1, fu_r2;
    logic        fu_e0, fu_e1, fu_e2;
    logic        inj_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_v <= 3'b000;
            fu_r0 <= 32'h0; fu_r1 <= 32'h0; fu_r2 <= 32'h0;
            fu_e0 <= 1'b0;  fu_e1 <= 1'b0;  fu_e2 <= 1'b0;
        end else begin
            fu_v  <= {fu_v[1:0], fu_start};
            fu_r0 <= ref_res(fu_a, fu_b, fu_sub);
            fu_e0 <= ref_exc(fu_a, fu_b, fu_sub);
            fu_r1 <= fu_r0; fu_r2 <= fu_r1;
            fu_e1 <= fu_e0; fu_e2 <= fu_e1;
        end
    end

    assign fu_done      = fu_v[2] | inj_done;
    assign fu_result    = fu_v[2] ? fu_r2 : 32'hDEADBEEF;
    assign fu_exception = fu_v[2] ? fu_e2 : 1'b0;

    // Scoreboard: every accepted pop must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got res=%h exc=%0b tag=%0d, expected none", out_result, out_exception, out_tag);
            end else begin
                logic [36:0] exp;
                exp = sb_q.pop_front();
                if ({out_result, out_exception, out_tag} !== exp) begin
                    bad++;
                    $display("FAIL sb_result got %h/%0b/%0d expected %h/%0b/%0d", out_result, out_exception, out_tag,
                             exp[36:5], exp[4], exp[3:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = s; in_tag = t;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got %0b exp 0", busy); end
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL rst_err got %0b exp 0", err_protocol); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_alive_early got %0b exp 0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_alive_set got %0b exp 1", in_ready); end
    endtask

    task automatic test_single(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t,
                               input logic [31:0] exp_res, input logic exp_exc);
        out_ready = 1'b1;
        tick();
        drive_op(a, b, s, t);
        #1;
        total++; if (fu_start !== 1'b1) begin bad++; $display("FAIL single_start got %0b exp 1", fu_start); end
        total++; if (fu_a !== a || fu_b !== b || fu_sub !== s) begin
            bad++; $display("FAIL single_operands got %h %h %0b exp %h %h %0b", fu_a, fu_b, fu_sub, a, b, s);
        end
        if (fu_start) sb_q.push_back({exp_res, exp_exc, t});
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early cycle %0d out_valid=%0b exp 0", c, out_valid); end
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_tag !== t || out_result !== exp_res || out_exception !== exp_exc) begin
            bad++; $display("FAIL single_cycle4 got v=%0b tag=%0d res=%h exc=%0b exp v=1 tag=%0d res=%h exc=%0b",
                            out_valid, out_tag, out_result, out_exception, t, exp_res, exp_exc);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        tick();
        drive_op(32'h40A00000, 32'h40400000, 1'b1, 4'd1);
        #1;
        total++; if (fu_start !== 1'b1) begin bad++; $display("FAIL b2b_start0 got %0b exp 1", fu_start); end
        sb_q.push_back({32'h40000000, 1'b0, 4'd1});
        tick();
        drive_op(32'h3F800000, 32'h3F800000, 1'b0, 4'd2);
        #1;
        total++; if (fu_start !== 1'b1) begin bad++; $display("FAIL b2b_start1 got %0b exp 1", fu_start); end
        sb_q.push_back({32'h40000000, 1'b0, 4'd2});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
            bad++; $display("FAIL b2b_first got v=%0b tag=%0d exp v=1 tag=1", out_valid, out_tag);
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_tag !== 4'd2) begin
            bad++; $display("FAIL b2b_second got v=%0b tag=%0d exp v=1 tag=2", out_valid, out_tag);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got %0b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int acc;
        int guard;
        acc = 0;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            logic [3:0] t;
            t = 4'(k + 8);
            drive_op(32'h00001000 + 32'(k), 32'h00FF0000, k[0], t);
            #1;
            if (in_ready) begin
                acc++;
                sb_q.push_back({(32'h00001000 + 32'(k)) ^ 32'h00FF0000, 1'b0, t});
            end
            tick();
        end
        in_valid = 1'b0;
        total++; if (acc != 4) begin bad++; $display("FAIL bp_accepts got %0d exp 4", acc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %0b exp 0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_buffered got %0b exp 1", out_valid); end
        out_ready = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got %0b exp 1", in_ready); end
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_drain_timeout busy=%0b exp 0", busy); end
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL bp_leftover got %0d exp 0", sb_q.size()); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        tick();
        drive_op(32'h11111111, 32'h01010101, 1'b0, 4'd3);
        #1;
        total++; if (fu_start !== 1'b1) begin bad++; $display("FAIL flush_acc0 got %0b exp 1", fu_start); end
        tick();
        drive_op(32'h22222222, 32'h01010101, 1'b1, 4'd4);
        tick();
        drive_op(32'h33333333, 32'h01010101, 1'b0, 4'd6);
        #1;
        total++; if (fu_start !== 1'b1) begin bad++; $display("FAIL flush_acc2 got %0b exp 1", fu_start); end
        tick();
        drive_op(32'h44444444, 32'h01010101, 1'b0, 4'd7);
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || fu_start !== 1'b0) begin
            bad++; $display("FAIL flush_block got ready=%0b start=%0b exp 0 0", in_ready, fu_start);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 4; c < 8; c++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cycle %0d out_valid=%0b exp 0", c, out_valid); end
            if (c == 5) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy5 got %0b exp 1", busy); end
            end
            if (c == 6) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy6 got %0b exp 0", busy); end
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
            end
            tick();
        end
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL flush_err got %0b exp 0", err_protocol); end
    endtask

    task automatic test_protocol_error();
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL perr_pre got %0b exp 0", err_protocol); end
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL perr_set got %0b exp 1", err_protocol); end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL perr_no_push got v=%0b busy=%0b exp 0 0", out_valid, busy);
        end
        repeat (5) tick();
        total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL perr_sticky got %0b exp 1", err_protocol); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        tick();
        drive_op(32'h3F800000, 32'h40000000, 1'b0, 4'd9);
        sb_q.push_back({32'h40400000, 1'b0, 4'd9});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        drive_op(32'h55555555, 32'h0000FFFF, 1'b0, 4'd10);
        tick();
        drive_op(32'h66666666, 32'h0000FFFF, 1'b1, 4'd11);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_setup got v=%0b busy=%0b exp 1 1", out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL mid_out_valid got %0b exp 0", out_valid); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL mid_busy got %0b exp 0", busy); end
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL mid_in_ready got %0b exp 0", in_ready); end
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL mid_err got %0b exp 0", err_protocol); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_alive_early got %0b exp 0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_alive_set got %0b exp 1", in_ready); end
        repeat (6) tick();
        total++; if (out_valid !== 1'b0 || err_protocol !== 1'b0) begin
            bad++; $display("FAIL mid_quiet got v=%0b err=%0b exp 0 0", out_valid, err_protocol);
        end
    endtask

    initial begin
        test_reset();
        test_single(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 1'b0);
        test_back_to_back();
        test_single(32'h7F800000, 32'hFF800000, 1'b0, 4'd12, 32'h7FC00000, 1'b1);
        test_backpressure();
        test_flush();
        test_protocol_error();
        test_reset_midflight();
        test_single(32'h40A00000, 32'h40400000, 1'b1, 4'd14, 32'h40000000, 1'b0);
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL final_leftover got %0d exp 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_issue_ctrl.md
Name: fpu_addsub_issue_ctrl

Overview:
Issue-side controller for the 3-stage pipelined FP add/sub unit, which has a fixed latency, no stall and a start/done interface. It accepts tagged ops from dispatch on a valid/ready handshake and drives the FU's start and operands. It pairs each done pulse with its tag and buffers results in a small FIFO, so the CDB/writeback arbiter can backpressure without ever stalling the FU. Credit-based admission guarantees the FIFO never overflows.

Parameters:
TAG_W, 4, ROB/RS tag width
FU_LAT, 3, FU latency in cycles from start to done
RES_DEPTH, 4, result FIFO depth; also the total credit count (power of 2, ≥ FU_LAT+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  single-cycle pipeline flush (mispredict/exception)
in_valid  in  1  dispatch op valid
in_ready  out  1  controller can accept the op
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B
in_sub  in  1  1 = A-B, 0 = A+B
in_tag  in  TAG_W  destination tag
fu_start  out  1  FU start pulse
fu_a  out  32  FU operand A
fu_b  out  32  FU operand B
fu_sub  out  1  FU AddBar_Sub
fu_done  in  1  FU result valid
fu_result  in  32  FU result
fu_exception  in  1  FU exception flag
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_result  out  32  result
out_exception  out  1  exception flag of result
out_tag  out  TAG_W  tag of result
busy  out  1  any op in flight or buffered
err_protocol  out  1  sticky: unexpected or missing fu_done, or push to a full FIFO

Behaviour:
- Reset (rst_n low): tag pipe cleared, FIFO empty, err_protocol=0, out_valid=0, busy=0, in_ready=0 (gated by a registered alive flop, reset 0, set 1 on the first clk edge after release).
- Credit: in_ready = alive & ~flush & (occ_cnt + fifo_cnt < RES_DEPTH).
  - occ_cnt counts occupied tag-pipe entries, killed entries included.
- Accept = in_valid & in_ready.
  - fu_start = accept, combinational.
  - fu_a/fu_b/fu_sub pass through in_a/in_b/in_sub combinationally.
- Tag pipe: FU_LAT entries {occ, keep, tag}.
  - Stage 0 loads {accept, accept, in_tag} at each edge; entries shift every cycle.
  - An op accepted in cycle 0 has fu_done expected in cycle FU_LAT, aligned with entry[FU_LAT-1].
- Completion: when entry[FU_LAT-1].occ=1 and fu_done=1:
  - keep=1: push {fu_result, fu_exception, tag} to the FIFO.
  - keep=0: drop the result silently.
- Error: fu_done != entry[FU_LAT-1].occ sets err_protocol; the result is dropped. A push while the FIFO is full (unreachable under credit) also sets err_protocol. err_protocol clears only on reset.
- FIFO: registered storage, RES_DEPTH entries, wrap-around read/write pointers plus a count.
  - out_* come from the head; out_valid = fifo_cnt != 0.
  - Pop = out_valid & out_ready.
  - Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
  - Latency from accept to out_valid is FU_LAT+1 = 4 cycles; back-to-back throughput is 1 op/cycle.
- Flush:
  - Same cycle: in_ready=0, no accept.
  - At the edge: every tag-pipe keep bit cleared (occ kept, so credits return only as killed ops drain), FIFO emptied.
  - A pop coincident with flush is discarded.
  - A done arriving in the flush cycle itself is also discarded.
- busy = |occ | (fifo_cnt != 0).
- Reset mid-operation: all state cleared asynchronously. Any later fu_done from the (also reset) FU is not expected; none occurs.

Decomposition:
- Shared package/header fpu_issue_pkg:
  - TAG_W, FU_LAT, RES_DEPTH defaults.
  - Tag-pipe entry typedef {occ, keep, tag}.
  - Result entry typedef {result[31:0], exception, tag}.
- One sub-module: fpu_result_fifo, a synchronous FIFO with a clear input, parameterised width and depth, exposing count.
- Tag pipe and credit logic stay in the top level.

Test Plan:
- Single op: a=0x3F800000, b=0x40000000, sub=0, tag=5 → fu_start in cycle 0; out_valid in cycle 4 with result=0x40400000, tag=5, exception=0.
- Back-to-back: ops 5.0-3.0 (0x40A00000 − 0x40400000, tag 1) then 1.0+1.0 (tag 2) on consecutive cycles, out_ready=1 → results 0x40000000/tag 1 then 0x40000000/tag 2 in cycles 4 and 5, in order.
- Backpressure: out_ready=0, in_valid held high → exactly 4 accepts, then in_ready=0. Raising out_ready drains 4 results in order; in_ready re-asserts the cycle after the first pop.
- Flush: 3 ops accepted, flush asserted in cycle 2 → no out_valid ever for those tags. busy drops after the killed ops drain (cycle 5). in_ready returns when credits free. err_protocol stays 0.
- Protocol error: inject a spurious fu_done with the tag pipe empty → err_protocol=1 and stays 1 until rst_n; no FIFO push.
- Reset mid-flight: rst_n low with 2 ops in flight and 1 buffered → out_valid=0, busy=0, in_ready=0 immediately. in_ready=1 one cycle after release.
